// File: rtl/uvmt_cv32e40x_obi_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uvmt_cv32e40x_obi_resp_pkg
// Brief   : Shared types and helpers for the OBI instruction responder.
// Revision: 1.0 - initial release
// ============================================================================
package uvmt_cv32e40x_obi_resp_pkg;

    localparam int unsigned ENTRY_TIMER_W = 8;   // supports RVALID_LATENCY up to 256
    localparam int unsigned ENTRY_DATA_W  = 32;
    localparam int unsigned ENTRY_ADDR_W  = 32;

    typedef struct packed {
        logic                     err;
        logic [ENTRY_TIMER_W-1:0] timer;
        logic [ENTRY_DATA_W-1:0]  data;
    } resp_entry_t;

    // An inverted window (lo > hi) can never match, so it is naturally empty.
    function automatic logic f_in_err_window(
        input logic                    en,
        input logic [ENTRY_ADDR_W-1:0] addr,
        input logic [ENTRY_ADDR_W-1:0] lo,
        input logic [ENTRY_ADDR_W-1:0] hi
    );
        return en && (addr >= lo) && (addr <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uvmt_cv32e40x_obi_resp_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uvmt_cv32e40x_obi_resp_fifo
// Brief   : Circular response buffer with per-entry latency timers.
// Revision: 1.0 - initial release
// ============================================================================
module uvmt_cv32e40x_obi_resp_fifo
    import uvmt_cv32e40x_obi_resp_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int LATENCY = 2,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_push,
    input  logic                    i_push_err,
    input  logic [ENTRY_DATA_W-1:0] i_cap_data,
    input  logic                    i_pop,
    output logic                    o_fire,
    output logic                    o_fire_err,
    output logic [ENTRY_DATA_W-1:0] o_fire_data,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [CNT_W-1:0]        o_count
);

    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    resp_entry_t          r_mem [DEPTH];
    logic [DEPTH-1:0]     r_valid;
    logic [c_IDX_W-1:0]   r_rd_ptr;
    logic [c_IDX_W-1:0]   r_wr_ptr;
    logic [c_IDX_W-1:0]   r_cap_idx;
    logic                 r_cap_en;
    logic [CNT_W-1:0]     r_count;

    logic [c_IDX_W-1:0]   w_cand;
    logic                 w_cand_ok;
    logic                 w_bypass;

    function automatic logic [c_IDX_W-1:0] f_next(input logic [c_IDX_W-1:0] p);
        return (p == c_IDX_W'(DEPTH - 1)) ? '0 : p + c_IDX_W'(1);
    endfunction

    // The head is still present during its own response cycle, so the next
    // entry to fire is the one behind it whenever a pop is in progress.
    always_comb begin
        w_cand      = i_pop ? f_next(r_rd_ptr) : r_rd_ptr;
        w_cand_ok   = r_valid[w_cand] && !(i_pop && (w_cand == r_rd_ptr));
        o_fire      = w_cand_ok && (r_mem[w_cand].timer == ENTRY_TIMER_W'(1));
        o_fire_err  = r_mem[w_cand].err;
        w_bypass    = r_cap_en && (w_cand == r_cap_idx);
        o_fire_data = r_mem[w_cand].data;
        if (w_bypass) begin
            o_fire_data = r_mem[w_cand].err ? '0 : i_cap_data;
        end
    end

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_valid   <= '0;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_cap_idx <= '0;
            r_cap_en  <= 1'b0;
            r_count   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_valid[i] && (r_mem[i].timer != '0)) begin
                    r_mem[i].timer <= r_mem[i].timer - ENTRY_TIMER_W'(1);
                end
            end
            if (r_cap_en) begin
                r_mem[r_cap_idx].data <= r_mem[r_cap_idx].err ? '0 : i_cap_data;
            end
            if (i_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= f_next(r_rd_ptr);
            end
            // A push into the slot being popped this cycle must win.
            if (i_push) begin
                r_mem[r_wr_ptr].err   <= i_push_err;
                r_mem[r_wr_ptr].timer <= ENTRY_TIMER_W'(LATENCY - 1);
                r_mem[r_wr_ptr].data  <= '0;
                r_valid[r_wr_ptr]     <= 1'b1;
                r_wr_ptr              <= f_next(r_wr_ptr);
                r_cap_idx             <= r_wr_ptr;
            end
            r_cap_en <= i_push;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uvmt_cv32e40x_obi_instr_responder.sv
`default_nettype none
// ============================================================================
// Module  : uvmt_cv32e40x_obi_instr_responder
// Brief   : OBI instruction-fetch slave: grant, memory read, timed responses.
// Revision: 1.0 - initial release
// ============================================================================
module uvmt_cv32e40x_obi_instr_responder
    import uvmt_cv32e40x_obi_resp_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int RVALID_LATENCY  = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               req_i,
    output logic                               gnt_o,
    input  logic [ADDR_WIDTH-1:0]              addr_i,
    input  logic [2:0]                         prot_i,
    input  logic                               dbg_i,
    input  logic [1:0]                         memtype_i,
    output logic                               rvalid_o,
    output logic [DATA_WIDTH-1:0]              rdata_o,
    output logic                               err_o,
    input  logic                               gnt_stall_i,
    input  logic                               err_en_i,
    input  logic [ADDR_WIDTH-1:0]              err_addr_lo_i,
    input  logic [ADDR_WIDTH-1:0]              err_addr_hi_i,
    output logic                               mem_req_o,
    output logic [ADDR_WIDTH-3:0]              mem_addr_o,
    input  logic [DATA_WIDTH-1:0]              mem_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                               proto_err_o
);

    localparam int c_CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic                    w_full;
    logic                    w_empty;
    logic                    w_fire;
    logic                    w_fire_err;
    logic [ENTRY_DATA_W-1:0] w_fire_data;
    logic                    w_accept;
    logic                    w_push_err;
    logic                    w_pop;
    logic                    w_changed;

    logic                    r_rvalid;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_err;

    logic                    r_pend;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [2:0]              r_prot;
    logic                    r_dbg;
    logic [1:0]              r_memtype;
    logic                    r_proto_err;

    // A slot freed by this cycle's response can be reused immediately.
    assign gnt_o    = req_i & ~gnt_stall_i & ~rst_i & (~w_full | r_rvalid);
    assign w_accept = req_i & gnt_o;
    assign w_pop    = r_rvalid & ~w_empty;

    assign w_push_err = f_in_err_window(err_en_i,
                                        ENTRY_ADDR_W'(addr_i),
                                        ENTRY_ADDR_W'(err_addr_lo_i),
                                        ENTRY_ADDR_W'(err_addr_hi_i));

    assign mem_req_o  = w_accept;
    assign mem_addr_o = addr_i[ADDR_WIDTH-1:2];

    uvmt_cv32e40x_obi_resp_fifo #(
        .DEPTH   (MAX_OUTSTANDING),
        .LATENCY (RVALID_LATENCY),
        .CNT_W   (c_CNT_W)
    ) u_fifo (
        .clk         (clk_i),
        .rst         (rst_i),
        .i_push      (w_accept),
        .i_push_err  (w_push_err),
        .i_cap_data  (ENTRY_DATA_W'(mem_rdata_i)),
        .i_pop       (w_pop),
        .o_fire      (w_fire),
        .o_fire_err  (w_fire_err),
        .o_fire_data (w_fire_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (outstanding_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= w_fire;
            r_rdata  <= w_fire ? DATA_WIDTH'(w_fire_data) : '0;
            r_err    <= w_fire & w_fire_err;
        end
    end

    assign rvalid_o = r_rvalid;
    assign rdata_o  = r_rdata;
    assign err_o    = r_err;

    // An ungranted request must be held with stable attributes next cycle.
    assign w_changed = (addr_i != r_addr) | (prot_i != r_prot) |
                       (dbg_i != r_dbg) | (memtype_i != r_memtype);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pend      <= 1'b0;
            r_addr      <= '0;
            r_prot      <= '0;
            r_dbg       <= 1'b0;
            r_memtype   <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_pend    <= req_i & ~gnt_o;
            r_addr    <= addr_i;
            r_prot    <= prot_i;
            r_dbg     <= dbg_i;
            r_memtype <= memtype_i;
            if (r_pend & (~req_i | w_changed)) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign proto_err_o = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_uvmt_cv32e40x_obi_instr_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_uvmt_cv32e40x_obi_instr_responder
// Brief   : Scoreboard bench for the OBI instruction responder.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uvmt_cv32e40x_obi_instr_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic [2:0]  prot;
    logic        dbg;
    logic [1:0]  memtype;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        gnt_stall;
    logic        err_en;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [1:0]  outst;
    logic        proto_err;

    logic        req1;
    logic        gnt1;
    logic [31:0] addr1;
    logic        rvalid1;
    logic [31:0] rdata1;
    logic        err1;
    logic        mem_req1;
    logic [29:0] mem_addr1;
    logic [31:0] mem_rdata1;
    logic [0:0]  outst1;
    logic        proto_err1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int max_out = 0;
    bit track   = 1'b0;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    uvmt_cv32e40x_obi_instr_responder u_dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .addr_i(addr),
        .prot_i(prot), .dbg_i(dbg), .memtype_i(memtype), .rvalid_o(rvalid),
        .rdata_o(rdata), .err_o(err), .gnt_stall_i(gnt_stall), .err_en_i(err_en),
        .err_addr_lo_i(lo), .err_addr_hi_i(hi), .mem_req_o(mem_req),
        .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata), .outstanding_o(outst),
        .proto_err_o(proto_err)
    );

    uvmt_cv32e40x_obi_instr_responder #(
        .MAX_OUTSTANDING(1), .RVALID_LATENCY(3)
    ) u_dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req1), .gnt_o(gnt1), .addr_i(addr1),
        .prot_i(3'd0), .dbg_i(1'b0), .memtype_i(2'd0), .rvalid_o(rvalid1),
        .rdata_o(rdata1), .err_o(err1), .gnt_stall_i(1'b0), .err_en_i(1'b0),
        .err_addr_lo_i(32'h0), .err_addr_hi_i(32'h0), .mem_req_o(mem_req1),
        .mem_addr_o(mem_addr1), .mem_rdata_i(mem_rdata1), .outstanding_o(outst1),
        .proto_err_o(proto_err1)
    );

    function automatic logic [31:0] mem_word(input logic [29:0] wa);
        case (wa)
            30'h000: return 32'h11111111;
            30'h001: return 32'h22222222;
            30'h002: return 32'h33333333;
            30'h003: return 32'h44444444;
            30'h020: return 32'h00000013;
            30'h400: return 32'hCAFEBABE;
            30'h401: return 32'h12345678;
            default: return 32'hDEAD0000 | {2'b00, wa};
        endcase
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_req)  mem_rdata  <= mem_word(mem_addr);
        if (mem_req1) mem_rdata1 <= mem_word(mem_addr1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (track && (int'(outst) > max_out)) max_out = int'(outst);
        if (rvalid) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp_unexpected: got rdata 0x%0h err %0b, want no response (cycle %0d)",
                         rdata, err, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_cycle", 64'(cyc), 64'(e.cyc));
                check("rsp_err", 64'(err), 64'(e.err));
                check("rsp_data", 64'(rdata), 64'(e.data));
            end
        end else begin
            check("idle_outputs_zero", {31'd0, err, rdata}, 64'd0);
        end
    end

    // Present one request and require an immediate grant.
    task automatic fetch_now(input logic [31:0] a, input logic e_err,
                             input logic [31:0] e_data, input bit expect_rsp);
        req  = 1'b1;
        addr = a;
        @(negedge clk);
        check("gnt_immediate", 64'(gnt), 64'd1);
        if (gnt && expect_rsp) sb.push_back('{cyc + 2, e_err, e_data});
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; addr = '0; prot = '0; dbg = 1'b0; memtype = '0;
        gnt_stall = 1'b0; err_en = 1'b0; lo = '0; hi = '0;
        req1 = 1'b0; addr1 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_outstanding", 64'(outst), 64'd0);
        check("reset_proto_err", 64'(proto_err), 64'd0);
        check("reset_rvalid", 64'(rvalid), 64'd0);
        @(posedge clk); #1;

        // Single fetch
        req = 1'b1; addr = 32'h80;
        @(negedge clk);
        check("single_gnt", 64'(gnt), 64'd1);
        check("single_mem_req", 64'(mem_req), 64'd1);
        check("single_mem_addr", 64'(mem_addr), 64'h20);
        sb.push_back('{cyc + 2, 1'b0, 32'h00000013});
        @(posedge clk); #1;
        idle(4);

        // Back-to-back streaming
        track = 1'b1;
        fetch_now(32'h0, 1'b0, 32'h11111111, 1'b1);
        fetch_now(32'h4, 1'b0, 32'h22222222, 1'b1);
        fetch_now(32'h8, 1'b0, 32'h33333333, 1'b1);
        fetch_now(32'hC, 1'b0, 32'h44444444, 1'b1);
        idle(4);
        track = 1'b0;
        check("stream_max_outstanding", 64'(max_out), 64'd2);

        // Error window, including inclusive bounds and an inverted window
        err_en = 1'b1; lo = 32'h1000; hi = 32'h1003;
        fetch_now(32'h1000, 1'b1, 32'h0, 1'b1);
        fetch_now(32'h1004, 1'b0, 32'h12345678, 1'b1);
        fetch_now(32'h1003, 1'b1, 32'h0, 1'b1);
        fetch_now(32'h0FFC, 1'b0, 32'hDEAD03FF, 1'b1);
        lo = 32'h2000; hi = 32'h1000;
        fetch_now(32'h1800, 1'b0, 32'hDEAD0600, 1'b1);
        err_en = 1'b0; lo = 32'h1000; hi = 32'h1003;
        fetch_now(32'h1000, 1'b0, 32'hCAFEBABE, 1'b1);
        idle(4);
        check("no_proto_err_yet", 64'(proto_err), 64'd0);

        // Stall with an address change while pending
        gnt_stall = 1'b1; req = 1'b1; addr = 32'h40;
        @(negedge clk);
        check("stall_gnt_c0", 64'(gnt), 64'd0);
        check("stall_proto_c0", 64'(proto_err), 64'd0);
        @(posedge clk); #1 addr = 32'h44;
        @(negedge clk);
        check("stall_gnt_c1", 64'(gnt), 64'd0);
        check("stall_proto_c1", 64'(proto_err), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("stall_gnt_c2", 64'(gnt), 64'd0);
        check("stall_proto_c2", 64'(proto_err), 64'd1);
        @(posedge clk); #1 gnt_stall = 1'b0;
        @(negedge clk);
        check("stall_release_gnt", 64'(gnt), 64'd1);
        if (gnt) sb.push_back('{cyc + 2, 1'b0, 32'hDEAD0011});
        @(posedge clk); #1;
        idle(4);
        check("proto_err_sticky", 64'(proto_err), 64'd1);

        // Reset after two accepts: only the first response escapes
        fetch_now(32'h200, 1'b0, 32'hDEAD0080, 1'b1);
        fetch_now(32'h204, 1'b0, 32'hDEAD0081, 1'b0);
        rst = 1'b1; req = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_outstanding", 64'(outst), 64'd0);
        check("rst_mid_proto_err", 64'(proto_err), 64'd0);
        @(posedge clk); #1;
        idle(4);
        fetch_now(32'h80, 1'b0, 32'h00000013, 1'b1);
        idle(4);

        // Single-slot instance: full, then same-cycle reuse on the response
        req1 = 1'b1; addr1 = 32'h100;
        @(negedge clk);
        check("full_gnt_t0", 64'(gnt1), 64'd1);
        @(posedge clk); #1 addr1 = 32'h104;
        @(negedge clk);
        check("full_gnt_t1", 64'(gnt1), 64'd0);
        check("full_outstanding_t1", 64'(outst1), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("full_gnt_t2", 64'(gnt1), 64'd0);
        check("full_rvalid_t2", 64'(rvalid1), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("full_gnt_t3", 64'(gnt1), 64'd1);
        check("full_rvalid_t3", 64'(rvalid1), 64'd1);
        check("full_rdata_t3", 64'(rdata1), 64'hDEAD0040);
        check("full_err_t3", 64'(err1), 64'd0);
        @(posedge clk); #1 req1 = 1'b0;
        @(negedge clk);
        check("full_rvalid_t4", 64'(rvalid1), 64'd0);
        check("full_outstanding_t4", 64'(outst1), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("full_rvalid_t5", 64'(rvalid1), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("full_rvalid_t6", 64'(rvalid1), 64'd1);
        check("full_rdata_t6", 64'(rdata1), 64'hDEAD0041);
        check("full_proto_err", 64'(proto_err1), 64'd0);
        @(posedge clk); #1;

        idle(6);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
